multiplication: RTL and testbench

MULTIPLICATION -- requirements
Module: multiplication

---
 rtl/fp_pkg.sv | 21 ++
 rtl/mantissa_mul24.sv | 12 +
 rtl/multiplication.sv | 94 +++++++++
 tb/tb_multiplication.sv | 116 +++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout and exponent constants
// used by the multiplier datapath.
package fp_pkg;

  localparam int EXP_BIAS   = 127;
  localparam int EXP_MAX    = 255;

  localparam int SIGN_W     = 1;
  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int SIG_W      = 24;
  localparam int PROD_W     = 2 * SIG_W;
  localparam int EXP_CALC_W = 10;

  localparam int SIGN_POS   = 31;
  localparam int EXP_MSB    = 30;
  localparam int EXP_LSB    = 23;
  localparam int FRAC_MSB   = 22;
  localparam int FRAC_LSB   = 0;

endpackage

// File: rtl/mantissa_mul24.sv
// Unsigned 24x24 significand multiplier producing the full 48-bit product.
module mantissa_mul24
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0]  a_i,
  input  logic [SIG_W-1:0]  b_i,
  output logic [PROD_W-1:0] product_o
);

  assign product_o = {{SIG_W{1'b0}}, a_i} * {{SIG_W{1'b0}}, b_i};

endmodule

// File: rtl/multiplication.sv
// Single-precision floating-point multiplier with one cycle of latency;
// normalise, round-to-nearest (ties truncate), exponent and flag logic.
module multiplication
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        valid_in,
  output logic        valid_out,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow
);

  logic [EXP_W-1:0]      expA, expB;
  logic [SIG_W-1:0]      sigA, sigB;
  logic [PROD_W-1:0]     product;
  logic                  sign, norm, roundUp, carry, isZero;
  logic [PROD_W-2:0]     normProd;
  logic [FRAC_W:0]       fracSum;
  logic [FRAC_W-1:0]     fraction;
  logic [EXP_CALC_W-1:0] expSum;

  logic [31:0] result_d, result_q;
  logic        exception_d, exception_q;
  logic        overflow_d, overflow_q;
  logic        underflow_d, underflow_q;
  logic        valid_q;

  assign expA = a_operand[EXP_MSB:EXP_LSB];
  assign expB = b_operand[EXP_MSB:EXP_LSB];
  // Denormals simply lose the hidden one; their exponent is left untouched.
  assign sigA = {|expA, a_operand[FRAC_MSB:FRAC_LSB]};
  assign sigB = {|expB, b_operand[FRAC_MSB:FRAC_LSB]};

  mantissa_mul24 u_mul (
    .a_i       (sigA),
    .b_i       (sigB),
    .product_o (product)
  );

  always_comb begin
    sign        = a_operand[SIGN_POS] ^ b_operand[SIGN_POS];
    norm        = product[PROD_W-1];
    normProd    = norm ? product[PROD_W-2:0] : {product[PROD_W-3:0], 1'b0};
    roundUp     = normProd[FRAC_W] & (|normProd[FRAC_W-1:0]);
    fracSum     = {1'b0, normProd[PROD_W-2:SIG_W]} + {{FRAC_W{1'b0}}, roundUp};
    carry       = fracSum[FRAC_W];
    fraction    = fracSum[FRAC_W-1:0];
    // Ten bits hold the full range -127..385 as a two's-complement value.
    expSum      = {2'b00, expA} + {2'b00, expB}
                + {{(EXP_CALC_W-1){1'b0}}, norm}
                + {{(EXP_CALC_W-1){1'b0}}, carry}
                - EXP_CALC_W'(EXP_BIAS);
    exception_d = (&expA) | (&expB);
    isZero      = (product == '0) & ~exception_d;
    overflow_d  = ($signed(expSum) >= $signed(EXP_CALC_W'(EXP_MAX))) & ~isZero;
    underflow_d = ($signed(expSum) <= $signed(EXP_CALC_W'(0))) & ~isZero;

    result_d = {sign, expSum[EXP_W-1:0], fraction};
    if (exception_d)     result_d = '0;
    else if (isZero)     result_d = {sign, {(EXP_W+FRAC_W){1'b0}}};
    else if (overflow_d) result_d = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (underflow_d) result_d = {sign, {(EXP_W+FRAC_W){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      exception_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        result_q    <= result_d;
        exception_q <= exception_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
      end
    end
  end

  assign valid_out = valid_q;
  assign result    = result_q;
  assign Exception = exception_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

endmodule

// File: tb/tb_multiplication.sv
// Directed-vector bench for the single-precision multiplier: table of
// hand-computed products plus reset, hold and back-to-back sequences.
module tb_multiplication;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_operand, b_operand;
  logic        valid_in;
  logic        valid_out;
  logic [31:0] result;
  logic        Exception, Overflow, Underflow;

  int vectorCount = 0;
  int missCount   = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    logic        expExc;
    logic        expOvf;
    logic        expUnf;
  } vec_t;

  vec_t vecs[10];

  multiplication dut (
    .clk       (clk),
    .reset     (reset),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .valid_in  (valid_in),
    .valid_out (valid_out),
    .result    (result),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] expRes,
                             input logic expExc, input logic expOvf,
                             input logic expUnf, input logic expValid);
    vectorCount++;
    if (result !== expRes || Exception !== expExc || Overflow !== expOvf ||
        Underflow !== expUnf || valid_out !== expValid) begin
      missCount++;
      $display("[TB] FAIL %s: got res=%h exc=%b ovf=%b unf=%b vld=%b, want res=%h exc=%b ovf=%b unf=%b vld=%b",
               name, result, Exception, Overflow, Underflow, valid_out,
               expRes, expExc, expOvf, expUnf, expValid);
    end
  endtask

  // Drive operands, let one rising edge capture them, then settle past it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic vin, input logic rst);
    a_operand = a;
    b_operand = b;
    valid_in  = vin;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"basic",      32'h4234851F, 32'h427C851F, 32'h453210EA, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"negB",       32'h4049999A, 32'hC1663D71, 32'hC2355063, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"bothNeg",    32'hC1526666, 32'hC240A3D7, 32'h441E5374, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"pow2",       32'h45800000, 32'h45800000, 32'h4B800000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"roundNorm",  32'h3ACA62C1, 32'h3ACA62C1, 32'h361FFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"zeroZero",   32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"negZero",    32'hC1526666, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"underflow",  32'h00800000, 32'h00180000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{"oneTimesOne",32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{"infInf",     32'h7F800000, 32'h7F800000, 32'h00000000, 1'b1, 1'b1, 1'b0};

    a_operand = '0;
    b_operand = '0;
    valid_in  = 1'b0;
    reset     = 1'b1;
    applyStimulus(32'h4234851F, 32'h427C851F, 1'b1, 1'b1);
    applyStimulus(32'h4234851F, 32'h427C851F, 1'b1, 1'b1);
    checkOutput("resetState", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      checkOutput(vecs[i].name, vecs[i].expResult, vecs[i].expExc,
                  vecs[i].expOvf, vecs[i].expUnf, 1'b1);
    end

    // Idle cycles with different operands must not disturb held outputs.
    applyStimulus(32'h45800000, 32'h45800000, 1'b0, 1'b0);
    checkOutput("hold1", vecs[9].expResult, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    checkOutput("hold2", vecs[9].expResult, 1'b1, 1'b1, 1'b0, 1'b0);

    applyStimulus(vecs[0].a, vecs[0].b, 1'b1, 1'b0);
    checkOutput("preReset", vecs[0].expResult, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(vecs[3].a, vecs[3].b, 1'b1, 1'b1);
    checkOutput("midReset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      checkOutput({"b2b_", vecs[i].name}, vecs[i].expResult, vecs[i].expExc,
                  vecs[i].expOvf, vecs[i].expUnf, 1'b1);
    end
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("b2bDrain", vecs[4].expResult, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
